prog_cpu_core: RTL and testbench

- Parametrised multi-cycle accumulator-free CPU core: synchronous program memory, register file, ALU, branch unit and a ready/valid output port.
- Next-generation replacement for the fixed 8-bit, 4-register, always-running core.
- Sits between the test/host loader (program load and start) and downstream consumers of computed results (output stream).
- Executes one instruction every two cycles plus output back-pressure stalls.

---
 rtl/prog_cpu_pkg.sv | 61 ++++++
 rtl/prog_cpu_alu.sv | 39 +++
 rtl/prog_cpu_core.sv | 186 ++++++++++++++++++
 tb/tb_prog_cpu_core.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_cpu_pkg.sv
// prog_cpu_pkg: shared definitions for the programmable CPU core.
//   - opcode encodings for the 4-bit op field
//   - FSM state enum
//   - field-extraction helpers for the {op, rd, imm} instruction word
// The helpers take the instruction zero-extended to INSTR_PAD_W bits plus the
// core's DATA_W / RSEL_W. Callers cast the result down to the field width.
package prog_cpu_pkg;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_LDI  = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_MOV  = 4'd7;
    localparam logic [3:0] OP_JMP  = 4'd8;
    localparam logic [3:0] OP_JZ   = 4'd9;
    localparam logic [3:0] OP_OUT  = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;
    localparam logic [3:0] OP_HALT = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_OUT_WAIT,
        ST_HALT
    } state_t;

    // Widest instruction word the helpers support (4 + RSEL_W + DATA_W).
    localparam int INSTR_PAD_W = 32;

    function automatic logic [3:0] f_op(input logic [INSTR_PAD_W-1:0] w,
                                        input int data_w, input int rsel_w);
        return 4'((w >> (data_w + rsel_w)) & 32'hF);
    endfunction

    function automatic logic [INSTR_PAD_W-1:0] f_rd(input logic [INSTR_PAD_W-1:0] w,
                                                    input int data_w, input int rsel_w);
        return (w >> data_w) & ((32'd1 << rsel_w) - 32'd1);
    endfunction

    function automatic logic [INSTR_PAD_W-1:0] f_imm(input logic [INSTR_PAD_W-1:0] w,
                                                     input int data_w);
        return w & ((32'd1 << data_w) - 32'd1);
    endfunction

    // rs1 occupies the top RSEL_W bits of imm.
    function automatic logic [INSTR_PAD_W-1:0] f_rs1(input logic [INSTR_PAD_W-1:0] w,
                                                     input int data_w, input int rsel_w);
        return (w >> (data_w - rsel_w)) & ((32'd1 << rsel_w) - 32'd1);
    endfunction

    // rs2 sits directly below rs1.
    function automatic logic [INSTR_PAD_W-1:0] f_rs2(input logic [INSTR_PAD_W-1:0] w,
                                                     input int data_w, input int rsel_w);
        return (w >> (data_w - 2 * rsel_w)) & ((32'd1 << rsel_w) - 32'd1);
    endfunction

endpackage

// File: rtl/prog_cpu_alu.sv
// prog_cpu_alu: combinational ALU for prog_cpu_core.
// Ports:
//   i_op     [3:0]        opcode (ADD, SUB, AND, OR, XOR, and MUL when enabled)
//   i_a, i_b [DATA_W-1:0] operands (rs1, rs2)
//   o_result [DATA_W-1:0] result truncated modulo 2^DATA_W
//   o_zero                result == 0
// Optional feature: define PROG_CPU_MUL_EN to add the MUL opcode. When it is
// undefined no multiplier is built and MUL yields 0 (the core ignores it).
module prog_cpu_alu
    import prog_cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [3:0]        i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_result,
    output logic              o_zero
);

    always_comb begin
        o_result = '0;
        case (i_op)
            OP_ADD:  o_result = i_a + i_b;
            OP_SUB:  o_result = i_a - i_b;
            OP_AND:  o_result = i_a & i_b;
            OP_OR:   o_result = i_a | i_b;
            OP_XOR:  o_result = i_a ^ i_b;
`ifdef PROG_CPU_MUL_EN
            // Only the low DATA_W bits of the product are kept.
            OP_MUL:  o_result = i_a * i_b;
`endif
            default: o_result = '0;
        endcase
    end

    assign o_zero = (o_result == '0);

endmodule

// File: rtl/prog_cpu_core.sv
// prog_cpu_core: multi-cycle programmable CPU core (FETCH/EXEC, 2 cycles per
// instruction) with synchronous program memory, register file, ALU, branch
// unit and a ready/valid output port.
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   start                 pulse: run from pc 0 (accepted in IDLE or HALT)
//   prog_we/addr/data     program-memory write (accepted in IDLE or HALT)
//   out_data/valid/ready  output stream, valid held until ready
//   pc, zero              program counter, zero flag of last ALU op
//   busy, halted          FETCH/EXEC/OUT_WAIT, HALT
//   dbg_sel, dbg_data     combinational register-file read
// Optional feature: PROG_CPU_MUL_EN enables opcode 11 (MUL); otherwise it is a NOP.
module prog_cpu_core
    import prog_cpu_pkg::*;
#(
    parameter  int DATA_W  = 8,
    parameter  int ADDR_W  = 4,
    parameter  int NREGS   = 4,
    localparam int RSEL_W  = $clog2(NREGS),
    localparam int INSTR_W = 4 + RSEL_W + DATA_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               prog_we,
    input  logic [ADDR_W-1:0]  prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ADDR_W-1:0]  pc,
    output logic               zero,
    output logic               busy,
    output logic               halted,
    input  logic [RSEL_W-1:0]  dbg_sel,
    output logic [DATA_W-1:0]  dbg_data
);

    state_t             r_state, w_state_next;
    logic [ADDR_W-1:0]  r_pc, w_pc_next;
    logic [DATA_W-1:0]  r_regs [NREGS];
    logic [INSTR_W-1:0] r_mem  [2**ADDR_W];
    logic [INSTR_W-1:0] r_instr;
    logic               r_zero;
    logic               r_out_valid;
    logic [DATA_W-1:0]  r_out_data;

    logic [INSTR_PAD_W-1:0] w_instr_pad;
    logic [3:0]             w_op;
    logic [RSEL_W-1:0]      w_rd, w_rs1, w_rs2;
    logic [DATA_W-1:0]      w_imm, w_a, w_b;
    logic [ADDR_W-1:0]      w_target;
    logic [DATA_W-1:0]      w_alu_result;
    logic                   w_alu_zero;
    logic                   w_reg_we, w_zero_we, w_out_load, w_out_clear;
    logic [DATA_W-1:0]      w_reg_wdata;
    logic                   w_prog_open;

    // Instruction decode from the fetched word
    assign w_instr_pad = INSTR_PAD_W'(r_instr);
    assign w_op        = f_op(w_instr_pad, DATA_W, RSEL_W);
    assign w_rd        = RSEL_W'(f_rd(w_instr_pad, DATA_W, RSEL_W));
    assign w_imm       = DATA_W'(f_imm(w_instr_pad, DATA_W));
    assign w_rs1       = RSEL_W'(f_rs1(w_instr_pad, DATA_W, RSEL_W));
    assign w_rs2       = RSEL_W'(f_rs2(w_instr_pad, DATA_W, RSEL_W));
    assign w_target    = ADDR_W'(w_imm);
    assign w_a         = r_regs[w_rs1];
    assign w_b         = r_regs[w_rs2];

    prog_cpu_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .i_op     (w_op),
        .i_a      (w_a),
        .i_b      (w_b),
        .o_result (w_alu_result),
        .o_zero   (w_alu_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_reg_we     = 1'b0;
        w_reg_wdata  = w_alu_result;
        w_zero_we    = 1'b0;
        w_out_load   = 1'b0;
        w_out_clear  = 1'b0;
        case (r_state)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    w_state_next = ST_FETCH;
                    w_pc_next    = '0;
                end
            end
            ST_FETCH: w_state_next = ST_EXEC;
            ST_EXEC: begin
                w_state_next = ST_FETCH;
                w_pc_next    = r_pc + 1'b1;
                case (w_op)
                    OP_LDI: begin
                        w_reg_we    = 1'b1;
                        w_reg_wdata = w_imm;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                        w_reg_we  = 1'b1;
                        w_zero_we = 1'b1;
                    end
                    OP_MUL: begin
`ifdef PROG_CPU_MUL_EN
                        w_reg_we  = 1'b1;
                        w_zero_we = 1'b1;
`endif
                    end
                    OP_MOV: begin
                        w_reg_we    = 1'b1;
                        w_reg_wdata = w_a;
                    end
                    OP_JMP: w_pc_next = w_target;
                    OP_JZ:  w_pc_next = r_zero ? w_target : r_pc + 1'b1;
                    OP_OUT: begin
                        // pc advances only once the transfer completes
                        w_out_load   = 1'b1;
                        w_pc_next    = r_pc;
                        w_state_next = ST_OUT_WAIT;
                    end
                    OP_HALT: begin
                        w_pc_next    = r_pc;
                        w_state_next = ST_HALT;
                    end
                    default: ;
                endcase
            end
            ST_OUT_WAIT: begin
                if (r_out_valid && out_ready) begin
                    w_out_clear  = 1'b1;
                    w_pc_next    = r_pc + 1'b1;
                    w_state_next = ST_FETCH;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc        <= '0;
            r_zero      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else begin
            r_pc <= w_pc_next;
            if (w_reg_we)  r_regs[w_rd] <= w_reg_wdata;
            if (w_zero_we) r_zero       <= w_alu_zero;
            if (w_out_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_a;
            end else if (w_out_clear) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Program memory is deliberately outside reset so a loaded program survives it.
    assign w_prog_open = (r_state == ST_IDLE) || (r_state == ST_HALT);

    always_ff @(posedge clk) begin
        if (prog_we && w_prog_open) r_mem[prog_addr] <= prog_data;
        if (r_state == ST_FETCH)    r_instr <= r_mem[r_pc];
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign pc        = r_pc;
    assign zero      = r_zero;
    assign busy      = (r_state == ST_FETCH) || (r_state == ST_EXEC) ||
                       (r_state == ST_OUT_WAIT);
    assign halted    = (r_state == ST_HALT);
    assign dbg_data  = r_regs[dbg_sel];

endmodule

// File: tb/tb_prog_cpu_core.sv
// Testbench for prog_cpu_core: directed programs from the test plan plus
// randomized forward-branching programs, all checked against an
// instruction-level interpreter of the instruction set.
module tb_prog_cpu_core;

    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 4;
    localparam int NREGS   = 4;
    localparam int RSEL_W  = 2;
    localparam int INSTR_W = 4 + RSEL_W + DATA_W;
    localparam int DEPTH   = 1 << ADDR_W;
    localparam int DMASK   = (1 << DATA_W) - 1;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic               prog_we = 1'b0;
    logic [ADDR_W-1:0]  prog_addr = '0;
    logic [INSTR_W-1:0] prog_data = '0;
    logic [DATA_W-1:0]  out_data;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [ADDR_W-1:0]  pc;
    logic               zero;
    logic               busy;
    logic               halted;
    logic [RSEL_W-1:0]  dbg_sel = '0;
    logic [DATA_W-1:0]  dbg_data;

    prog_cpu_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pc        (pc),
        .zero      (zero),
        .busy      (busy),
        .halted    (halted),
        .dbg_sel   (dbg_sel),
        .dbg_data  (dbg_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // ---------------- program image and ISA reference model ----------------
    logic [INSTR_W-1:0] prog [DEPTH];
    int m_regs [NREGS];
    int m_zero;
    int m_pc;
    int m_outq [$];

    function automatic logic [INSTR_W-1:0] enc(input int op, input int rd, input int imm);
        return INSTR_W'((op << (RSEL_W + DATA_W)) | (rd << DATA_W) | (imm & DMASK));
    endfunction

    function automatic logic [INSTR_W-1:0] enc_r(input int op, input int rd,
                                                 input int rs1, input int rs2);
        return enc(op, rd, (rs1 << (DATA_W - RSEL_W)) | (rs2 << (DATA_W - 2 * RSEL_W)));
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < DEPTH; i++) prog[i] = '0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) m_regs[i] = 0;
        m_zero = 0;
        m_pc   = 0;
    endtask

    // Runs the program from pc 0 with the current register/flag state until HALT.
    task automatic model_run();
        int p;
        int steps;
        int w, op, rd, imm, a, b, r;
        bit done;
        p = 0; steps = 0; done = 0;
        m_outq.delete();
        while (!done && steps < 500) begin
            w   = int'(prog[p]);
            op  = (w >> (RSEL_W + DATA_W)) & 15;
            rd  = (w >> DATA_W) & (NREGS - 1);
            imm = w & DMASK;
            a   = m_regs[(imm >> (DATA_W - RSEL_W)) & (NREGS - 1)];
            b   = m_regs[(imm >> (DATA_W - 2 * RSEL_W)) & (NREGS - 1)];
            steps++;
            case (op)
                1: begin m_regs[rd] = imm; p = (p + 1) % DEPTH; end
                2, 3, 4, 5, 6: begin
                    case (op)
                        2:       r = (a + b) % (DMASK + 1);
                        3:       r = (a - b + DMASK + 1) % (DMASK + 1);
                        4:       r = a & b;
                        5:       r = a | b;
                        default: r = a ^ b;
                    endcase
                    m_regs[rd] = r;
                    m_zero = (r == 0) ? 1 : 0;
                    p = (p + 1) % DEPTH;
                end
                7:  begin m_regs[rd] = a; p = (p + 1) % DEPTH; end
                8:  p = imm % DEPTH;
                9:  p = (m_zero != 0) ? imm % DEPTH : (p + 1) % DEPTH;
                10: begin m_outq.push_back(a); p = (p + 1) % DEPTH; end
                11: begin
`ifdef PROG_CPU_MUL_EN
                    r = (a * b) % (DMASK + 1);
                    m_regs[rd] = r;
                    m_zero = (r == 0) ? 1 : 0;
`endif
                    p = (p + 1) % DEPTH;
                end
                15: done = 1;
                default: p = (p + 1) % DEPTH;
            endcase
        end
        m_pc = p;
    endtask

    // ---------------- DUT drivers ----------------
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic load_prog();
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            prog_we   = 1'b1;
            prog_addr = ADDR_W'(i);
            prog_data = prog[i];
        end
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic check_reg(input string tag, input int idx, input int exp);
        dbg_sel = RSEL_W'(idx);
        #1;
        chk(tag, dbg_data, exp);
    endtask

    int last_out, n_out, n_valid, first_valid;

    task automatic run_dut(input bit rand_ready);
        int cyc;
        bit prev_hold;
        int prev_data;
        cyc = 0; prev_hold = 0; prev_data = 0;
        n_out = 0; n_valid = 0; first_valid = -1; last_out = -1;
        @(negedge clk);
        start = 1'b1;
        chk("start_cycle_busy", busy, 0);
        @(negedge clk);
        start = 1'b0;
        while (!halted && cyc < 2000) begin
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (prev_hold) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, prev_data);
            end
            if (out_valid) begin
                n_valid++;
                if (first_valid < 0) first_valid = cyc;
            end
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
            if (out_valid && out_ready) begin
                if (n_out < m_outq.size()) chk("out_data", out_data, m_outq[n_out]);
                else                       chk("out_count_live", n_out + 1, m_outq.size());
                last_out = out_data;
                n_out++;
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b1;
        chk("halted", halted, 1);
        chk("out_count", n_out, m_outq.size());
        chk("final_pc", pc, m_pc);
        chk("final_zero", zero, m_zero);
        chk("final_busy", busy, 0);
        chk("final_valid", out_valid, 0);
        for (int i = 0; i < NREGS; i++) check_reg("final_reg", i, m_regs[i]);
    endtask

    task automatic run_and_check(input bit rand_ready);
        load_prog();
        model_run();
        run_dut(rand_ready);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int cyc;
        int op, imm;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state
        chk("rst_pc", pc, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_zero", zero, 0);
        for (int i = 0; i < NREGS; i++) check_reg("rst_reg", i, 0);

        // Basic program
        clear_prog();
        prog[0] = enc(1, 0, 5);
        prog[1] = enc(1, 1, 3);
        prog[2] = enc_r(2, 2, 0, 1);
        prog[3] = enc_r(10, 0, 2, 0);
        prog[4] = enc(15, 0, 0);
        run_and_check(1'b0);
        chk("basic_out", last_out, 8);
        chk("basic_valid_cycles", n_valid, 1);
        chk("basic_first_valid_cycle", first_valid, 8);
        chk("basic_pc", pc, 4);

        // SUB wrap and branches
        clear_prog();
        prog[0] = enc(1, 0, 5);
        prog[1] = enc(1, 1, 3);
        prog[2] = enc(1, 3, 'h77);
        prog[3] = enc_r(3, 2, 1, 0);
        prog[4] = enc(9, 0, 8);
        prog[5] = enc_r(3, 3, 0, 0);
        prog[6] = enc(9, 0, 8);
        prog[7] = enc(15, 0, 0);
        prog[8] = enc_r(10, 0, 2, 0);
        prog[9] = enc(15, 0, 0);
        run_and_check(1'b1);
        chk("sub_out", last_out, 'hFE);
        check_reg("sub_r2", 2, 'hFE);
        check_reg("sub_r3", 3, 0);
        chk("sub_zero", zero, 1);
        chk("sub_pc", pc, 9);

        // Back-pressure
        clear_prog();
        prog[0] = enc(1, 1, 'h5A);
        prog[1] = enc_r(10, 0, 1, 0);
        prog[2] = enc(15, 0, 0);
        load_prog();
        model_run();
        out_ready = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 50) begin @(negedge clk); cyc++; end
        chk("bp_valid_seen", out_valid, 1);
        for (int k = 0; k < 4; k++) begin
            chk("bp_valid", out_valid, 1);
            chk("bp_data", out_data, 'h5A);
            chk("bp_pc", pc, 1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_valid_drop", out_valid, 0);
        chk("bp_pc_after", pc, 2);
        chk("bp_busy_after", busy, 1);
        cyc = 0;
        while (!halted && cyc < 50) begin @(negedge clk); cyc++; end
        chk("bp_halted", halted, 1);
        chk("bp_final_pc", pc, m_pc);

        // pc wrap over an all-NOP memory, with a blocked program write
        do_reset();
        clear_prog();
        load_prog();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 36; k++) begin
            chk("wrap_pc", pc, ((k - 1) / 2) % DEPTH);
            chk("wrap_busy", busy, 1);
            prog_we   = (k == 5);
            prog_addr = ADDR_W'(3);
            prog_data = enc(15, 0, 0);
            @(negedge clk);
        end
        prog_we = 1'b0;
        do_reset();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            chk("wrap_rerun_pc", pc, (k - 1) / 2);
            @(negedge clk);
        end
        chk("wrap_rerun_busy", busy, 1);
        do_reset();

        // Reset during OUT_WAIT, then rerun the retained program
        clear_prog();
        prog[0] = enc(1, 0, 5);
        prog[1] = enc(1, 1, 3);
        prog[2] = enc_r(2, 2, 0, 1);
        prog[3] = enc_r(10, 0, 2, 0);
        prog[4] = enc(15, 0, 0);
        load_prog();
        out_ready = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 50) begin @(negedge clk); cyc++; end
        chk("rst_ow_valid_seen", out_valid, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        model_reset();
        chk("rst_ow_valid", out_valid, 0);
        chk("rst_ow_busy", busy, 0);
        chk("rst_ow_halted", halted, 0);
        chk("rst_ow_pc", pc, 0);
        for (int i = 0; i < NREGS; i++) check_reg("rst_ow_reg", i, 0);
        model_run();
        run_dut(1'b0);
        chk("rerun_out", last_out, 8);
        chk("rerun_pc", pc, 4);

        // MUL with 15*17 and 16*16 (NOP when the multiplier is not built)
        clear_prog();
        prog[0] = enc(1, 0, 15);
        prog[1] = enc(1, 1, 17);
        prog[2] = enc(1, 2, 'h33);
        prog[3] = enc_r(3, 3, 0, 0);
        prog[4] = enc_r(11, 2, 0, 1);
        prog[5] = enc(15, 0, 0);
        run_and_check(1'b1);
`ifdef PROG_CPU_MUL_EN
        check_reg("mul1_r2", 2, 'hFF);
        chk("mul1_zero", zero, 0);
`else
        check_reg("mul1_r2", 2, 'h33);
        chk("mul1_zero", zero, 1);
`endif
        clear_prog();
        prog[0] = enc(1, 0, 16);
        prog[1] = enc(1, 2, 'h44);
        prog[2] = enc_r(2, 3, 0, 0);
        prog[3] = enc_r(11, 2, 0, 0);
        prog[4] = enc(15, 0, 0);
        run_and_check(1'b1);
`ifdef PROG_CPU_MUL_EN
        check_reg("mul2_r2", 2, 0);
        chk("mul2_zero", zero, 1);
`else
        check_reg("mul2_r2", 2, 'h44);
        chk("mul2_zero", zero, 0);
`endif

        // Random forward-branching programs, random back-pressure
        for (int t = 0; t < 10; t++) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                op = int'($urandom_range(0, 14));
                if (op == 8 || op == 9)
                    imm = (int'($urandom_range(0, 15)) << ADDR_W) |
                          int'($urandom_range(i + 1, DEPTH - 1));
                else
                    imm = int'($urandom_range(0, DMASK));
                prog[i] = enc(op, int'($urandom_range(0, NREGS - 1)), imm);
            end
            prog[DEPTH-1] = enc(15, 0, 0);
            run_and_check(1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
